// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Supported major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // pc_src encodings
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;

  // wb_sel encodings
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  // alu_op encodings that the FSM forces itself
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  // JALR, SYSTEM and anything unknown fall through to illegal
  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_LOAD, OP_IMM, OP_STORE,
      OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // Immediate ALU ops only honour instr[30] for the shift-right pair (funct3=101);
  // for every other funct3 that bit is immediate data, not an opcode modifier.
  function automatic logic [3:0] imm_alu_op(input logic [3:0] fn);
    return {fn[3:1], (fn[3:1] == 3'b101) ? fn[0] : 1'b0};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags the cycle on which the wait budget runs out.
// Latency: expired is combinational in the TIMEOUT-th consecutive wait cycle.
// Backpressure: none; clr wins over cnt_en, TIMEOUT=0 never expires.
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Wait-cycle counter: cleared between requests and on every completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt_en && (TIMEOUT != 0)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt already holds TIMEOUT-1 completed waits, so this wait is the last allowed
  assign expired = (TIMEOUT != 0) && cnt_en && (cnt == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, write-back.
// Latency: branch 3, ALU/lui/auipc/jal/store 4, load 5 cycles plus memory waits.
// Backpressure: mem_req holds until mem_ready; wait overrun halts with fault.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [3:0]       func,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_data,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             fault,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  state_t           state_q;
  logic [6:0]       op_q;
  logic [3:0]       func_q;
  logic             illegal_q;
  logic             fault_q;
  logic [CNT_W-1:0] instret_q;

  logic wait_clr;
  logic wait_cnt_en;
  logic wait_expired;

  // Instruction class of the decoded (registered) opcode
  logic is_r, is_imm, is_load, is_store, is_branch, is_jal, is_lui, is_auipc;
  assign is_r      = (op_q == OP_R);
  assign is_imm    = (op_q == OP_IMM);
  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BRANCH);
  assign is_jal    = (op_q == OP_JAL);
  assign is_lui    = (op_q == OP_LUI);
  assign is_auipc  = (op_q == OP_AUIPC);

  // Counter is held at zero outside the two memory states, so every entry starts fresh
  assign wait_clr    = !((state_q == S_FETCH) || (state_q == S_MEM)) || mem_ready;
  assign wait_cnt_en = mem_req && !mem_ready;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wait_clr),
    .cnt_en  (wait_cnt_en),
    .expired (wait_expired)
  );

  // State sequencing, decode capture, sticky flags and retirement count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      func_q    <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      if (pc_we) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            state_q <= S_DECODE;
          end else if (wait_expired) begin
            state_q <= S_HALT;
            fault_q <= 1'b1;
          end
        end
        S_DECODE: begin
          op_q   <= opcode;
          func_q <= func;
          if (op_supported(opcode)) begin
            state_q <= S_EXEC;
          end else begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (is_load || is_store) state_q <= S_MEM;
          else if (is_branch)      state_q <= run ? S_FETCH : S_IDLE;
          else                     state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_store) state_q <= run ? S_FETCH : S_IDLE;
            else          state_q <= S_WB;
          end else if (wait_expired) begin
            state_q <= S_HALT;
            fault_q <= 1'b1;
          end
        end
        S_WB: begin
          state_q <= run ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath strobes decoded from state and decoded class; ready/taken gate same-cycle
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_EXEC: begin
        if (is_r) begin
          alu_op = func_q;
        end else if (is_imm) begin
          alu_src_b = 1'b1;
          alu_op    = imm_alu_op(func_q);
        end else if (is_load || is_store) begin
          alu_src_b = 1'b1;
          alu_op    = ALU_ADD;
        end else if (is_auipc) begin
          alu_src_a = 1'b1;
          alu_src_b = 1'b1;
          alu_op    = ALU_ADD;
        end else if (is_branch) begin
          alu_op = ALU_SUB;
          pc_we  = 1'b1;
          pc_src = branch_taken ? PC_IMM : PC_PLUS4;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = is_store;
        if (mem_ready && is_store) begin
          pc_we  = 1'b1;
          pc_src = PC_PLUS4;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        if (is_load) begin
          wb_sel = WB_MEM;
        end else if (is_jal) begin
          wb_sel = WB_PC4;
          pc_src = PC_IMM;
        end else if (is_lui) begin
          wb_sel = WB_IMM;
        end
      end
      default: begin
      end
    endcase
  end

  assign illegal = illegal_q;
  assign fault   = fault_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control words, flags and counter.
// Latency: stimulus applied 1 time unit after each rising edge, checked 1 unit later.
// Backpressure: mem_ready patterns exercise waits, timeout and run-drop paths.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic [6:0]       opcode = '0;
  logic [3:0]       func = '0;
  logic             branch_taken = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, mem_sel_data, ir_we, pc_we;
  logic [1:0]       pc_src;
  logic             alu_src_a, alu_src_b;
  logic [3:0]       alu_op;
  logic             rf_we;
  logic [1:0]       wb_sel;
  logic             illegal, fault;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state;

  int tests_run = 0;
  int tests_failed = 0;

  multicycle_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .func(func),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_sel_data(mem_sel_data), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal), .fault(fault),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  wire [15:0] ctl_obs = {mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src,
                         alu_src_a, alu_src_b, alu_op, rf_we, wb_sel};

  typedef struct packed {
    logic [6:0]  op;
    logic [3:0]  fn;
    logic        run;
    logic        rdy;
    logic        tkn;
    logic [2:0]  st;
    logic [15:0] c;
    logic [1:0]  fl;   // {illegal, fault}
  } vec_t;

  localparam logic [6:0] XOP = 7'b1111111;  // junk opcode outside DECODE

  function automatic logic [15:0] ctl(input logic mreq, mwe, msel, irwe, pcwe,
                                      input logic [1:0] pcs, input logic asa, asb,
                                      input logic [3:0] aop, input logic rfwe,
                                      input logic [1:0] wbs);
    return {mreq, mwe, msel, irwe, pcwe, pcs, asa, asb, aop, rfwe, wbs};
  endfunction

  function automatic vec_t mk(input logic [6:0] op, input logic [3:0] fn,
                              input logic r, rdy, tkn, input logic [2:0] st,
                              input logic [15:0] c, input logic [1:0] fl);
    vec_t v;
    v.op = op; v.fn = fn; v.run = r; v.rdy = rdy; v.tkn = tkn;
    v.st = st; v.c = c; v.fl = fl;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    opcode = v.op; func = v.fn; run = v.run; mem_ready = v.rdy; branch_taken = v.tkn;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    opcode = '0; func = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1;
    opcode = 7'b0110011; func = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({state, ctl_obs, illegal, fault, instret} !== {3'(S_IDLE), 16'h0, 2'b00, 3'd0}) begin
      tests_failed++;
      $display("FAIL reset_state got st=%0d ctl=%h il=%b ft=%b ir=%0d want all zero",
               state, ctl_obs, illegal, fault, instret);
    end
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({state, ctl_obs} !== {3'(S_FETCH), ctl(1,0,0,0,0,0,0,0,0,0,0)}) begin
      tests_failed++;
      $display("FAIL reset_fetch_stall got st=%0d ctl=%h want st=%0d ctl=8000", state, ctl_obs, S_FETCH);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({state, ctl_obs} !== {3'(S_IDLE), 16'h0}) begin
      tests_failed++;
      $display("FAIL reset_abandon got st=%0d ctl=%h want st=0 ctl=0000", state, ctl_obs);
    end
  endtask

  task automatic test_add();
    vec_t v[$];
    logic [6:0] op = 7'b0110011;
    do_reset();
    tests_run++;
    if (instret !== 3'd0) begin
      tests_failed++;
      $display("FAIL add_instret_pre got %0d want 0", instret);
    end
    v.push_back(mk(op, 4'h0, 1, 1, 0, S_IDLE,   16'h0,                          2'b00));
    v.push_back(mk(op, 4'h0, 1, 1, 0, S_FETCH,  ctl(1,0,0,1,0,0,0,0,0,0,0),     2'b00));
    v.push_back(mk(op, 4'h0, 1, 1, 0, S_DECODE, 16'h0,                          2'b00));
    v.push_back(mk(op, 4'h0, 1, 1, 0, S_EXEC,   ctl(0,0,0,0,0,0,0,0,0,0,0),     2'b00));
    v.push_back(mk(op, 4'h0, 0, 1, 0, S_WB,     ctl(0,0,0,0,1,0,0,0,0,1,2'b00), 2'b00));
    v.push_back(mk(op, 4'h0, 0, 1, 0, S_IDLE,   16'h0,                          2'b00));
    foreach (v[i]) begin
      apply(v[i]);
      #1;
      tests_run++;
      if ({state, ctl_obs, illegal, fault} !== {v[i].st, v[i].c, v[i].fl}) begin
        tests_failed++;
        $display("FAIL add[%0d] st/ctl/fl got %0d/%h/%b want %0d/%h/%b",
                 i, state, ctl_obs, {illegal, fault}, v[i].st, v[i].c, v[i].fl);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (instret !== 3'd1) begin
      tests_failed++;
      $display("FAIL add_instret got %0d want 1", instret);
    end
  endtask

  task automatic test_load();
    vec_t v[$];
    logic [6:0] op = 7'b0000011;
    logic [15:0] cm = ctl(1,0,1,0,0,0,0,0,0,0,0);
    do_reset();
    v.push_back(mk(op, 4'h4, 1, 1, 0, S_IDLE,   16'h0,                          2'b00));
    v.push_back(mk(op, 4'h4, 1, 1, 0, S_FETCH,  ctl(1,0,0,1,0,0,0,0,0,0,0),     2'b00));
    v.push_back(mk(op, 4'h4, 1, 1, 0, S_DECODE, 16'h0,                          2'b00));
    v.push_back(mk(op, 4'h4, 1, 1, 0, S_EXEC,   ctl(0,0,0,0,0,0,0,1,0,0,0),     2'b00));
    v.push_back(mk(op, 4'h4, 1, 0, 0, S_MEM,    cm,                             2'b00));
    v.push_back(mk(op, 4'h4, 1, 0, 0, S_MEM,    cm,                             2'b00));
    v.push_back(mk(op, 4'h4, 1, 0, 0, S_MEM,    cm,                             2'b00));
    v.push_back(mk(op, 4'h4, 1, 1, 0, S_MEM,    cm,                             2'b00));
    v.push_back(mk(op, 4'h4, 0, 1, 0, S_WB,     ctl(0,0,0,0,1,0,0,0,0,1,2'b01), 2'b00));
    v.push_back(mk(op, 4'h4, 0, 1, 0, S_IDLE,   16'h0,                          2'b00));
    foreach (v[i]) begin
      apply(v[i]);
      #1;
      tests_run++;
      if ({state, ctl_obs, illegal, fault} !== {v[i].st, v[i].c, v[i].fl}) begin
        tests_failed++;
        $display("FAIL load[%0d] st/ctl/fl got %0d/%h/%b want %0d/%h/%b",
                 i, state, ctl_obs, {illegal, fault}, v[i].st, v[i].c, v[i].fl);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (instret !== 3'd1) begin
      tests_failed++;
      $display("FAIL load_instret got %0d want 1", instret);
    end
  endtask

  task automatic test_branch();
    vec_t v[$];
    logic [6:0] op = 7'b1100011;
    do_reset();
    v.push_back(mk(op, 4'h0, 1, 1, 1, S_IDLE,   16'h0,                             2'b00));
    v.push_back(mk(op, 4'h0, 1, 1, 1, S_FETCH,  ctl(1,0,0,1,0,0,0,0,0,0,0),        2'b00));
    v.push_back(mk(op, 4'h0, 1, 1, 1, S_DECODE, 16'h0,                             2'b00));
    v.push_back(mk(op, 4'h0, 1, 1, 1, S_EXEC,   ctl(0,0,0,0,1,2'b01,0,0,4'b0001,0,0), 2'b00));
    v.push_back(mk(op, 4'h0, 1, 1, 0, S_FETCH,  ctl(1,0,0,1,0,0,0,0,0,0,0),        2'b00));
    v.push_back(mk(op, 4'h0, 1, 1, 0, S_DECODE, 16'h0,                             2'b00));
    v.push_back(mk(op, 4'h0, 0, 1, 0, S_EXEC,   ctl(0,0,0,0,1,2'b00,0,0,4'b0001,0,0), 2'b00));
    v.push_back(mk(op, 4'h0, 0, 1, 1, S_IDLE,   16'h0,                             2'b00));
    foreach (v[i]) begin
      apply(v[i]);
      #1;
      tests_run++;
      if ({state, ctl_obs, illegal, fault} !== {v[i].st, v[i].c, v[i].fl}) begin
        tests_failed++;
        $display("FAIL branch[%0d] st/ctl/fl got %0d/%h/%b want %0d/%h/%b",
                 i, state, ctl_obs, {illegal, fault}, v[i].st, v[i].c, v[i].fl);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (instret !== 3'd2) begin
      tests_failed++;
      $display("FAIL branch_instret got %0d want 2", instret);
    end
  endtask

  task automatic test_illegal();
    vec_t v[$];
    logic [6:0] op = 7'b1100111;
    do_reset();
    v.push_back(mk(op, 4'h0, 1, 1, 0, S_IDLE,   16'h0,                      2'b00));
    v.push_back(mk(op, 4'h0, 1, 1, 0, S_FETCH,  ctl(1,0,0,1,0,0,0,0,0,0,0), 2'b00));
    v.push_back(mk(op, 4'h0, 1, 1, 0, S_DECODE, 16'h0,                      2'b00));
    v.push_back(mk(op, 4'h0, 1, 1, 1, S_HALT,   16'h0,                      2'b10));
    v.push_back(mk(op, 4'h0, 1, 1, 1, S_HALT,   16'h0,                      2'b10));
    foreach (v[i]) begin
      apply(v[i]);
      #1;
      tests_run++;
      if ({state, ctl_obs, illegal, fault} !== {v[i].st, v[i].c, v[i].fl}) begin
        tests_failed++;
        $display("FAIL illegal[%0d] st/ctl/fl got %0d/%h/%b want %0d/%h/%b",
                 i, state, ctl_obs, {illegal, fault}, v[i].st, v[i].c, v[i].fl);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (instret !== 3'd0) begin
      tests_failed++;
      $display("FAIL illegal_instret got %0d want 0", instret);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({state, illegal} !== {3'(S_IDLE), 1'b0}) begin
      tests_failed++;
      $display("FAIL illegal_reset got st=%0d il=%b want st=0 il=0", state, illegal);
    end
  endtask

  task automatic test_timeout();
    vec_t v[$];
    logic [6:0] op = 7'b0110011;
    logic [15:0] cw = ctl(1,0,0,0,0,0,0,0,0,0,0);
    do_reset();
    v.push_back(mk(op, 4'h0, 1, 0, 0, S_IDLE,  16'h0, 2'b00));
    v.push_back(mk(op, 4'h0, 1, 0, 0, S_FETCH, cw,    2'b00));
    v.push_back(mk(op, 4'h0, 1, 0, 0, S_FETCH, cw,    2'b00));
    v.push_back(mk(op, 4'h0, 1, 0, 0, S_FETCH, cw,    2'b00));
    v.push_back(mk(op, 4'h0, 1, 0, 0, S_FETCH, cw,    2'b00));
    v.push_back(mk(op, 4'h0, 1, 1, 0, S_HALT,  16'h0, 2'b01));
    v.push_back(mk(op, 4'h0, 1, 1, 0, S_HALT,  16'h0, 2'b01));
    foreach (v[i]) begin
      apply(v[i]);
      #1;
      tests_run++;
      if ({state, ctl_obs, illegal, fault} !== {v[i].st, v[i].c, v[i].fl}) begin
        tests_failed++;
        $display("FAIL timeout[%0d] st/ctl/fl got %0d/%h/%b want %0d/%h/%b",
                 i, state, ctl_obs, {illegal, fault}, v[i].st, v[i].c, v[i].fl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_run_drop();
    vec_t v[$];
    logic [6:0] op = 7'b0100011;
    logic [15:0] cs = ctl(1,1,1,0,0,0,0,0,0,0,0);
    do_reset();
    v.push_back(mk(op, 4'h4, 1, 0, 0, S_IDLE,   16'h0,                      2'b00));
    v.push_back(mk(op, 4'h4, 1, 0, 0, S_FETCH,  ctl(1,0,0,0,0,0,0,0,0,0,0), 2'b00));
    v.push_back(mk(op, 4'h4, 1, 0, 0, S_FETCH,  ctl(1,0,0,0,0,0,0,0,0,0,0), 2'b00));
    v.push_back(mk(op, 4'h4, 1, 0, 0, S_FETCH,  ctl(1,0,0,0,0,0,0,0,0,0,0), 2'b00));
    v.push_back(mk(op, 4'h4, 1, 1, 0, S_FETCH,  ctl(1,0,0,1,0,0,0,0,0,0,0), 2'b00));
    v.push_back(mk(op, 4'h4, 1, 1, 0, S_DECODE, 16'h0,                      2'b00));
    v.push_back(mk(op, 4'h4, 1, 1, 0, S_EXEC,   ctl(0,0,0,0,0,0,0,1,0,0,0), 2'b00));
    v.push_back(mk(op, 4'h4, 0, 0, 0, S_MEM,    cs,                         2'b00));
    v.push_back(mk(op, 4'h4, 0, 0, 0, S_MEM,    cs,                         2'b00));
    v.push_back(mk(op, 4'h4, 0, 0, 0, S_MEM,    cs,                         2'b00));
    v.push_back(mk(op, 4'h4, 0, 1, 0, S_MEM,    ctl(1,1,1,0,1,0,0,0,0,0,0), 2'b00));
    v.push_back(mk(op, 4'h4, 0, 1, 0, S_IDLE,   16'h0,                      2'b00));
    v.push_back(mk(op, 4'h4, 0, 1, 0, S_IDLE,   16'h0,                      2'b00));
    foreach (v[i]) begin
      apply(v[i]);
      #1;
      tests_run++;
      if ({state, ctl_obs, illegal, fault} !== {v[i].st, v[i].c, v[i].fl}) begin
        tests_failed++;
        $display("FAIL store[%0d] st/ctl/fl got %0d/%h/%b want %0d/%h/%b",
                 i, state, ctl_obs, {illegal, fault}, v[i].st, v[i].c, v[i].fl);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (instret !== 3'd1) begin
      tests_failed++;
      $display("FAIL store_instret got %0d want 1", instret);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    logic [6:0]  ops [6];
    logic [3:0]  fns [6];
    logic [15:0] exs [6];
    logic [15:0] wbs [6];
    logic [15:0] wb_alu = ctl(0,0,0,0,1,0,0,0,0,1,2'b00);
    ops[0] = 7'b0110011; fns[0] = 4'b0001; exs[0] = ctl(0,0,0,0,0,0,0,0,4'b0001,0,0); wbs[0] = wb_alu;
    ops[1] = 7'b0010011; fns[1] = 4'b1011; exs[1] = ctl(0,0,0,0,0,0,0,1,4'b1011,0,0); wbs[1] = wb_alu;
    ops[2] = 7'b0010011; fns[2] = 4'b0011; exs[2] = ctl(0,0,0,0,0,0,0,1,4'b0010,0,0); wbs[2] = wb_alu;
    ops[3] = 7'b0010111; fns[3] = 4'b0001; exs[3] = ctl(0,0,0,0,0,0,1,1,4'b0000,0,0); wbs[3] = wb_alu;
    ops[4] = 7'b0110111; fns[4] = 4'b1111; exs[4] = 16'h0; wbs[4] = ctl(0,0,0,0,1,0,0,0,0,1,2'b11);
    ops[5] = 7'b1101111; fns[5] = 4'b0000; exs[5] = 16'h0; wbs[5] = ctl(0,0,0,0,1,2'b01,0,0,0,1,2'b10);
    do_reset();
    v.push_back(mk(XOP, 4'h0, 1, 1, 0, S_IDLE, 16'h0, 2'b00));
    for (int k = 0; k < 6; k++) begin
      v.push_back(mk(XOP,    4'h0,   1, 1, 0, S_FETCH,  ctl(1,0,0,1,0,0,0,0,0,0,0), 2'b00));
      v.push_back(mk(ops[k], fns[k], 1, 1, 0, S_DECODE, 16'h0,                      2'b00));
      v.push_back(mk(XOP,    4'h0,   1, 1, 1, S_EXEC,   exs[k],                     2'b00));
      v.push_back(mk(XOP,    4'h0,   (k != 5), 1, 1, S_WB, wbs[k],                  2'b00));
    end
    v.push_back(mk(XOP, 4'h0, 0, 1, 0, S_IDLE, 16'h0, 2'b00));
    foreach (v[i]) begin
      apply(v[i]);
      #1;
      tests_run++;
      if ({state, ctl_obs, illegal, fault} !== {v[i].st, v[i].c, v[i].fl}) begin
        tests_failed++;
        $display("FAIL b2b[%0d] st/ctl/fl got %0d/%h/%b want %0d/%h/%b",
                 i, state, ctl_obs, {illegal, fault}, v[i].st, v[i].c, v[i].fl);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (instret !== 3'd6) begin
      tests_failed++;
      $display("FAIL b2b_instret got %0d want 6", instret);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    opcode = 7'b1100011; func = 4'h0; run = 1'b1; mem_ready = 1'b1; branch_taken = 1'b0;
    @(posedge clk); #1;
    repeat (21) @(posedge clk);
    #1;
    tests_run++;
    if ({state, instret} !== {3'(S_FETCH), 3'b111}) begin
      tests_failed++;
      $display("FAIL wrap_max got st=%0d instret=%0d want st=%0d instret=7", state, instret, S_FETCH);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({state, instret} !== {3'(S_FETCH), 3'b000}) begin
      tests_failed++;
      $display("FAIL wrap_zero got st=%0d instret=%0d want st=%0d instret=0", state, instret, S_FETCH);
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_illegal();
    test_timeout();
    test_store_run_drop();
    test_back_to_back();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
